aes_inv_cipher_iter: RTL and testbench

- Parametrised, iterative AES inverse cipher: one round per clock, key length selectable (AES-128/192/256 via NR), optional CBC chaining.
- Successor to the fixed AES-128 decryption top. Adds a valid/ready handshake on input and output, backpressure, and IV/chain handling.
- Round keys come from an external key-schedule register file through an index/data port. This block contains no key expansion.

---
 rtl/aes_pkg.sv | 104 ++++++++++
 rtl/aes_inv_round.sv | 28 ++
 rtl/aes_inv_cipher_iter.sv | 151 +++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES inverse cipher:
//   - legal round counts (NR_128 / NR_192 / NR_256)
//   - FSM state encoding
//   - inverse S-box table and GF(2^8) multiply helpers (polynomial 0x11B)
//   - inv_shift_rows / inv_sub_bytes / inv_mix_columns on 128-bit states
// State layout follows FIPS-197: byte i sits in bits [127-8*i -: 8], and
// byte index i = 4*column + row (column-major fill).
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_t;

  // NOTE: this table is a constant that synthesis folds into logic; it is not
  // a storage array, so there is nothing to reset.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x (xtime) modulo 0x11B.
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product; with a constant b the loop reduces to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_mul2(p);
    end
    return acc;
  endfunction

  // Row r is rotated right by r positions: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  // Each column multiplied by the circulant {0e, 0b, 0d, 09}.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = gf_mul(a[r],           8'h0e) ^
                                    gf_mul(a[(r + 1) % 4], 8'h0b) ^
                                    gf_mul(a[(r + 2) % 4], 8'h0d) ^
                                    gf_mul(a[(r + 3) % 4], 8'h09);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse round:
//   out = InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ rk)
// with the InvMixColumns step bypassed when final_round is set.
// Ports:
//   state_in    128  current cipher state
//   rk          128  round key for this round
//   final_round   1  1 = last round (no InvMixColumns)
//   state_out   128  next cipher state
// -----------------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [127:0] keyed;

  always_comb begin
    keyed     = inv_sub_bytes(inv_shift_rows(state_in)) ^ rk;
    state_out = final_round ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative AES inverse cipher, one round per clock, AES-128/192/256 via NR,
// optional CBC chaining (CBC_EN). Round keys are fetched from an external
// key-schedule file: rk_idx selects, rk returns the key in the same cycle.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   ciphertext handshake, in_data = ciphertext block
//   iv_load, iv         load the chain register (IDLE only, CBC only)
//   rk_idx, rk          round-key request / response
//   out_valid/out_ready plaintext handshake, out_data = plaintext block
//   busy                high while rounds are being computed
// -----------------------------------------------------------------------------
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR     = NR_128,
  parameter bit CBC_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         iv_load,
  input  logic [127:0] iv,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] NR_M1  = 4'(NR - 1);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q;
  logic [3:0]   ctr_q;
  logic         out_valid_q;
  logic [127:0] out_data_q;
  logic [127:0] chain;
  logic [127:0] round_out;
  logic         last_round;
  logic         in_fire;
  logic         out_fire;

  assign last_round = (ctr_q == 4'd0);
  assign in_fire    = (fsm_q == ST_IDLE) && in_valid;
  assign out_fire   = (fsm_q == ST_DONE) && out_ready;

  aes_inv_round u_round (
    .state_in    (st_q),
    .rk          (rk),
    .final_round (last_round),
    .state_out   (round_out)
  );

  // rk_idx depends only on FSM state and counter, never on inputs, so the
  // key file can answer combinationally without forming a loop.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    fsm_d    = fsm_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    rk_idx   = NR_IDX;
    unique case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = ST_ROUND;
      end
      ST_ROUND: begin
        busy   = 1'b1;
        rk_idx = ctr_q;
        if (last_round) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q <= ST_IDLE;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the values from before the edge, regardless of statement order.
      fsm_q <= fsm_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= '0;
      ctr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (in_fire) begin
        // Initial AddRoundKey uses the last key of the schedule.
        st_q  <= in_data ^ rk;
        ctr_q <= NR_M1;
      end else if (fsm_q == ST_ROUND) begin
        st_q <= round_out;
        if (!last_round) begin
          ctr_q <= ctr_q - 4'd1;
        end else begin
          out_valid_q <= 1'b1;
          out_data_q  <= round_out ^ chain;
        end
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  if (CBC_EN) begin : g_cbc
    logic [127:0] chain_q;
    logic [127:0] cipher_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        chain_q  <= '0;
        cipher_q <= '0;
      end else begin
        if (in_fire) cipher_q <= in_data;
        // iv_load together with in_valid makes iv the chain for that block.
        if ((fsm_q == ST_IDLE) && iv_load) chain_q <= iv;
        else if (out_fire)                 chain_q <= cipher_q;
      end
    end

    assign chain = chain_q;
  end else begin : g_ecb
    logic unused_iv;
    assign unused_iv = ^{iv_load, iv};
    assign chain     = '0;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
// Two instances: index 0 is NR=10 with CBC, index 1 is NR=14 in ECB mode.
// The bench owns the key schedule (its own expansion built on an S-box it
// derives from GF(2^8) inversion plus the affine map) and a forward AES
// encryptor used to build ciphertexts for random plaintexts.
// -----------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic [1:0]         in_valid, in_ready, iv_load, out_valid, out_ready, busy;
  logic [1:0][127:0]  in_data, iv, rk, out_data;
  logic [1:0][3:0]    rk_idx;

  logic [127:0] rks [2][16];
  logic [7:0]   sbox_t [256];

  int checks   = 0;
  int failures = 0;

  assign rk[0] = rks[0][rk_idx[0]];
  assign rk[1] = rks[1][rk_idx[1]];

  aes_inv_cipher_iter #(.NR(10), .CBC_EN(1'b1)) u_dut10 (
    .clk (clk), .reset_n (reset_n),
    .in_valid (in_valid[0]), .in_ready (in_ready[0]), .in_data (in_data[0]),
    .iv_load (iv_load[0]), .iv (iv[0]),
    .rk_idx (rk_idx[0]), .rk (rk[0]),
    .out_valid (out_valid[0]), .out_ready (out_ready[0]), .out_data (out_data[0]),
    .busy (busy[0])
  );

  aes_inv_cipher_iter #(.NR(14), .CBC_EN(1'b0)) u_dut14 (
    .clk (clk), .reset_n (reset_n),
    .in_valid (in_valid[1]), .in_ready (in_ready[1]), .in_data (in_data[1]),
    .iv_load (iv_load[1]), .iv (iv[1]),
    .rk_idx (rk_idx[1]), .rk (rk[1]),
    .out_valid (out_valid[1]), .out_ready (out_ready[1]), .out_data (out_data[1]),
    .busy (busy[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
    end
    return 8'h00;
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = ginv(8'(x));
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
                  {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // key is left-aligned in 256 bits; nk = 4, 6 or 8 words.
  task automatic expand(input int k, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input int k, input int nr, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ rks[k][0];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[v[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = t[i];
      v = v ^ rks[k][rnd];
    end
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking and driving ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input int k, input logic [127:0] d, input logic ld, input logic [127:0] ivv);
    int n;
    n = 0;
    while (!in_ready[k] && n < 100) begin tick(); n++; end
    check("send_ready", 128'(in_ready[k]), 128'd1);
    in_valid[k] = 1'b1; in_data[k] = d; iv_load[k] = ld; iv[k] = ivv;
    tick();
    in_valid[k] = 1'b0; iv_load[k] = 1'b0;
  endtask

  // Returns the number of clock edges from the handshake edge to out_valid.
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 200) begin tick(); lat++; end
    check("out_valid_seen", 128'(out_valid[k]), 128'd1);
  endtask

  task automatic accept(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    check("out_valid_drop", 128'(out_valid[k]), 128'd0);
    check("in_ready_back", 128'(in_ready[k]), 128'd1);
  endtask

  task automatic recv(input int k, input logic [127:0] exp, input string tag, input int hold);
    int lat;
    wait_out(k, lat);
    repeat (hold) tick();
    check(tag, out_data[k], exp);
    accept(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [127:0] pt, ct, prev, ivr;

    reset_n = 1'b0;
    in_valid = '0; iv_load = '0; out_ready = '0; in_data = '0; iv = '0;
    for (int k = 0; k < 2; k++) for (int r = 0; r < 16; r++) rks[k][r] = '0;
    build_sbox();

    // Reset values while reset is held.
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", 128'(out_valid[k]), 128'd0);
      check("rst_out_data", out_data[k], 128'd0);
      check("rst_busy", 128'(busy[k]), 128'd0);
      check("rst_in_ready", 128'(in_ready[k]), 128'd1);
    end
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_rk_idx10", 128'(rk_idx[0]), 128'd10);
    check("idle_rk_idx14", 128'(rk_idx[1]), 128'd14);

    // FIPS-197 C.1 on the CBC instance: chain is zero after reset.
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, '0);
    check("c1_busy", 128'(busy[0]), 128'd1);
    check("c1_rk_idx", 128'(rk_idx[0]), 128'd9);
    check("c1_in_ready", 128'(in_ready[0]), 128'd0);
    wait_out(0, lat);
    check("c1_latency", 128'(lat), 128'd10);
    check("c1_data", out_data[0], 128'h00112233445566778899aabbccddeeff);

    // Backpressure: hold the output for 20 cycles, poke in_valid meanwhile.
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin in_valid[0] = 1'b1; in_data[0] = rand128(); end
      if (i == 6) in_valid[0] = 1'b0;
      tick();
      check("bp_valid", 128'(out_valid[0]), 128'd1);
      check("bp_data", out_data[0], 128'h00112233445566778899aabbccddeeff);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    accept(0);
    repeat (3) tick();
    check("bp_no_ghost", 128'(out_valid[0]), 128'd0);

    // SP800-38A F.2.2, iv loaded in the same cycle as block 1.
    expand(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    send(0, 128'h7649abac8119b246cee98e9b12e9197d, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    recv(0, 128'h6bc1bee22e409f96e93d7e117393172a, "cbc_blk1", 0);
    send(0, 128'h5086cb9b507219ee95db113a917678b2, 1'b0, '0);
    repeat (2) tick();
    iv_load[0] = 1'b1; iv[0] = rand128();
    tick();
    iv_load[0] = 1'b0;
    recv(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, "cbc_blk2", 1);

    // FIPS-197 C.3 on the NR=14 ECB instance.
    expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    send(1, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, '0);
    check("c3_busy", 128'(busy[1]), 128'd1);
    check("c3_rk_idx", 128'(rk_idx[1]), 128'd13);
    wait_out(1, lat);
    check("c3_latency", 128'(lat), 128'd14);
    check("c3_data", out_data[1], 128'h00112233445566778899aabbccddeeff);
    accept(1);

    // Random CBC stream on the NR=10 instance.
    expand(0, {rand128(), 128'h0}, 4);
    ivr  = rand128();
    prev = ivr;
    for (int b = 0; b < 4; b++) begin
      pt   = rand128();
      ct   = encrypt(0, 10, pt ^ prev);
      prev = ct;
      send(0, ct, (b == 0), ivr);
      recv(0, pt, "rand_cbc", int'($urandom_range(0, 3)));
    end

    // Random ECB blocks on the NR=14 instance; iv_load must be inert there.
    expand(1, {rand128(), rand128()}, 8);
    for (int b = 0; b < 3; b++) begin
      pt = rand128();
      ct = encrypt(1, 14, pt);
      send(1, ct, 1'b1, rand128());
      recv(1, pt, "rand_ecb14", int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a block: output suppressed, chain cleared.
    pt = rand128();
    send(0, encrypt(0, 10, pt ^ prev), 1'b0, '0);
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("mid_rst_busy", 128'(busy[0]), 128'd0);
    check("mid_rst_out_data", out_data[0], 128'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("post_rst_out_valid", 128'(out_valid[0]), 128'd0);
    pt = rand128();
    send(0, encrypt(0, 10, pt), 1'b0, '0);
    recv(0, pt, "post_rst_ecb", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
